// File: rtl/nios2_cpu_debug_ocimem_seq.sv
// rtl/nios2_cpu_debug_ocimem_seq.sv - debug-slave OCIMEM single-word read/write sequencer
// Optional transfer watchdog enabled by defining OCIMEM_TIMEOUT_EN.
module nios2_cpu_debug_ocimem_seq #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_REQ} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [31:0]       wdata_nx, mon_nx;
  logic              ready_nx, error_nx;
  logic              any_strobe;
  logic              timed_out;
  logic              unused_ok;

  assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign mem_address = addr;
  assign unused_ok   = ^{jdo[37:36], jdo[2:0], 16'(TIMEOUT)};

`ifdef OCIMEM_TIMEOUT_EN
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;

  // Counter is zero in the first busy cycle, so the abort lands after TIMEOUT busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= '0;
    else if (state == IDLE) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 16'd1;
  end

  assign timed_out = (state != IDLE) && (wait_cnt == WAIT_LIMIT);
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    wdata_nx = mem_writedata;
    mon_nx   = MonDReg;
    ready_nx = monitor_ready;
    error_nx = monitor_error;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          addr_nx  = jdo[ADDR_W+16:17];
          error_nx = 1'b0;
          if (jdo[35]) begin
            state_nx = RD_REQ;
            ready_nx = 1'b0;
          end else begin
            ready_nx = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_nx = jdo[34:3];
          state_nx = WR_REQ;
          ready_nx = 1'b0;
          error_nx = 1'b0;
        end else if (take_no_action_ocimem_a) begin
          state_nx = RD_REQ;
          ready_nx = 1'b0;
          error_nx = 1'b0;
        end
      end
      RD_REQ: begin
        if (!mem_waitrequest) begin
          // Data returned in the acceptance cycle completes the read immediately.
          if (mem_readdatavalid) begin
            mon_nx   = mem_readdata;
            addr_nx  = addr + ADDR_W'(1);
            ready_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = RD_DATA;
          end
        end else if (timed_out) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          error_nx = 1'b1;
        end
      end
      RD_DATA: begin
        if (mem_readdatavalid) begin
          mon_nx   = mem_readdata;
          addr_nx  = addr + ADDR_W'(1);
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else if (timed_out) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          error_nx = 1'b1;
        end
      end
      WR_REQ: begin
        if (!mem_waitrequest) begin
          addr_nx  = addr + ADDR_W'(1);
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else if (timed_out) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
          error_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Collisions with a busy sequencer are flagged but never disturb the transfer.
    if (state != IDLE && any_strobe) error_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_writedata <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_nx;
      addr          <= addr_nx;
      mem_read      <= (state_nx == RD_REQ);
      mem_write     <= (state_nx == WR_REQ);
      mem_writedata <= wdata_nx;
      MonDReg       <= mon_nx;
      monitor_ready <= ready_nx;
      monitor_error <= error_nx;
    end
  end

endmodule
